// File: rtl/ram_buf_pkg.sv
// rtl/ram_buf_pkg.sv - shared widths, types and parity helper for ram_wr_buffer
package ram_buf_pkg;

  // Default geometry; the top derives its own widths from its DEPTH parameter.
  localparam int DEPTH_DEF = 16;

  // Pointer width for a given depth (at least one bit so tiny buffers still elaborate).
  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w_f(DEPTH_DEF);

  // Pointer and occupancy types for the default geometry.
  typedef logic [ADDR_W_DEF-1:0] ptr_t;
  typedef logic [ADDR_W_DEF:0]   cnt_t;

  // Even parity bit: callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_buf_mem.sv
// rtl/ram_buf_mem.sv - plain storage array, one write port and one registered read port
module ram_buf_mem
  import ram_buf_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = addr_w_f(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; a same-address write in the same cycle returns the old word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/ram_wr_buffer.sv
// rtl/ram_wr_buffer.sv - circular write buffer with occupancy and sticky error flags (option: RAM_WR_BUFFER_PARITY_EN)
module ram_wr_buffer
  import ram_buf_pkg::*;
#(
  parameter  int SIZE_DATA = 8,
  parameter  int DEPTH     = 16,
  localparam int ADDR_W    = addr_w_f(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_data_wr,
`ifdef RAM_WR_BUFFER_PARITY_EN
  input  logic                 i_par_inj,
`endif
  input  logic                 i_rd_en,
  output logic                 o_rd_valid,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_parity_err
);

`ifdef RAM_WR_BUFFER_PARITY_EN
  localparam int MEM_W = SIZE_DATA + 1;
`else
  localparam int MEM_W = SIZE_DATA;
`endif
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              full_q, empty_q, rd_valid_q, ovf_q, unf_q;
  logic              rd_acc, wr_acc;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  // Accept decisions; clear wins over any request, and a full buffer takes a write only alongside a read.
  always_comb begin
    rd_acc    = i_rd_en & ~empty_q & ~i_clr;
    wr_acc    = i_wr_en & (~full_q | rd_acc) & ~i_clr;
    count_nxt = count_q;
    if (wr_acc & ~rd_acc)      count_nxt = count_q + (ADDR_W+1)'(1);
    else if (rd_acc & ~wr_acc) count_nxt = count_q - (ADDR_W+1)'(1);
  end

`ifdef RAM_WR_BUFFER_PARITY_EN
  assign mem_wdata    = {even_par(64'(i_data_wr)) ^ i_par_inj, i_data_wr};
  assign o_data_rd    = mem_rdata[SIZE_DATA-1:0];
  assign o_parity_err = rd_valid_q & (even_par(64'(mem_rdata[SIZE_DATA-1:0])) ^ mem_rdata[SIZE_DATA]);
`else
  assign mem_wdata    = i_data_wr;
  assign o_data_rd    = mem_rdata;
  assign o_parity_err = 1'b0;
`endif

  ram_buf_mem #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wr_ptr),
    .i_wr_data (mem_wdata),
    .i_rd_en   (rd_acc),
    .i_rd_addr (rd_ptr),
    .o_rd_data (mem_rdata)
  );

  // Pointers, occupancy, registered full/empty, read-valid strobe and sticky error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (i_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      count_q    <= count_nxt;
      full_q     <= (count_nxt == FULL_CNT);
      empty_q    <= (count_nxt == '0);
      rd_valid_q <= rd_acc;
      if (i_wr_en & ~wr_acc) ovf_q <= 1'b1;
      if (i_rd_en & empty_q) unf_q <= 1'b1;
    end
  end

  assign o_rd_valid  = rd_valid_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_ram_wr_buffer.sv
// tb/tb_ram_wr_buffer.sv - vector table plus data scoreboard for ram_wr_buffer (DEPTH=4, option: RAM_WR_BUFFER_PARITY_EN)
module tb_ram_wr_buffer;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [7:0] data_wr;
`ifdef RAM_WR_BUFFER_PARITY_EN
  logic       par_inj;
`endif
  logic       rd_valid, full, empty, ovf, unf, perr;
  logic [7:0] data_rd;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       c, w;
    logic [7:0] d;
    logic       r;
    logic [2:0] cnt;
    logic       f, e, o, u;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] last_data;

  always #5 clk = ~clk;

  ram_wr_buffer #(.SIZE_DATA(8), .DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr        (clr),
    .i_wr_en      (wr_en),
    .i_data_wr    (data_wr),
`ifdef RAM_WR_BUFFER_PARITY_EN
    .i_par_inj    (par_inj),
`endif
    .i_rd_en      (rd_en),
    .o_rd_valid   (rd_valid),
    .o_data_rd    (data_rd),
    .o_full       (full),
    .o_empty      (empty),
    .o_count      (count),
    .o_overflow   (ovf),
    .o_underflow  (unf),
    .o_parity_err (perr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic w, input logic [7:0] d, input logic r,
                     input logic [2:0] cnt, input logic f, input logic e, input logic o, input logic u);
    vec_t v;
    v.c = c; v.w = w; v.d = d; v.r = r; v.cnt = cnt; v.f = f; v.e = e; v.o = o; v.u = u;
    vecs.push_back(v);
  endtask

  // One clock: drive on negedge, predict via the queue model, check read side 1 ns after the edge.
  task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r, input logic pe);
    logic       racc, wacc;
    logic [7:0] exp_d;
    @(negedge clk);
    clr = c; wr_en = w; data_wr = d; rd_en = r;
    racc = r && !c && (mq.size() != 0);
    wacc = w && !c && ((mq.size() < 4) || racc);
    if (c) mq.delete();
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    @(posedge clk);
    #1;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'(racc));
    if (rd_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got data %0h expected no read", data_rd);
      end else begin
        exp_d = sb.pop_front();
        chk("rd_data", 32'(data_rd), 32'(exp_d));
        last_data = exp_d;
      end
    end else begin
      chk("data_hold", 32'(data_rd), 32'(last_data));
    end
    chk("parity_err", 32'(perr), 32'(racc ? pe : 1'b0));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_wr = 8'h00;
`ifdef RAM_WR_BUFFER_PARITY_EN
    par_inj = 1'b0;
`endif
    last_data = 8'h00;

    // basic order
    add(0,1,8'h11,0, 3'd1,0,0,0,0);
    add(0,1,8'h22,0, 3'd2,0,0,0,0);
    add(0,1,8'h33,0, 3'd3,0,0,0,0);
    add(0,0,8'h00,1, 3'd2,0,0,0,0);
    add(0,0,8'h00,1, 3'd1,0,0,0,0);
    add(0,0,8'h00,1, 3'd0,0,1,0,0);
    // full and overflow
    add(0,1,8'hA0,0, 3'd1,0,0,0,0);
    add(0,1,8'hA1,0, 3'd2,0,0,0,0);
    add(0,1,8'hA2,0, 3'd3,0,0,0,0);
    add(0,1,8'hA3,0, 3'd4,1,0,0,0);
    add(0,1,8'hFF,0, 3'd4,1,0,1,0);
    add(0,0,8'h00,1, 3'd3,0,0,1,0);
    add(0,0,8'h00,1, 3'd2,0,0,1,0);
    add(0,0,8'h00,1, 3'd1,0,0,1,0);
    add(0,0,8'h00,1, 3'd0,0,1,1,0);
    // clear, then fill and stream across the pointer wrap
    add(1,0,8'h00,0, 3'd0,0,1,0,0);
    add(0,1,8'hA0,0, 3'd1,0,0,0,0);
    add(0,1,8'hA1,0, 3'd2,0,0,0,0);
    add(0,1,8'hA2,0, 3'd3,0,0,0,0);
    add(0,1,8'hA3,0, 3'd4,1,0,0,0);
    for (int i = 0; i < 6; i++) add(0,1,8'hB0 + 8'(i),1, 3'd4,1,0,0,0);
    add(0,0,8'h00,1, 3'd3,0,0,0,0);
    add(0,0,8'h00,1, 3'd2,0,0,0,0);
    add(0,0,8'h00,1, 3'd1,0,0,0,0);
    add(0,0,8'h00,1, 3'd0,0,1,0,0);
    // empty: underflow, then write+read while empty
    add(0,0,8'h00,1, 3'd0,0,1,0,1);
    add(0,1,8'h5A,1, 3'd1,0,0,0,1);
    add(0,0,8'h00,1, 3'd0,0,1,0,1);
    // count=3 with both flags set, then clear with a write
    add(0,1,8'hC1,0, 3'd1,0,0,0,1);
    add(0,1,8'hC2,0, 3'd2,0,0,0,1);
    add(0,1,8'hC3,0, 3'd3,0,0,0,1);
    add(0,1,8'hC4,0, 3'd4,1,0,0,1);
    add(0,1,8'hC5,0, 3'd4,1,0,1,1);
    add(0,0,8'h00,1, 3'd3,0,0,1,1);
    add(1,1,8'hEE,0, 3'd0,0,1,0,0);
    add(0,0,8'h00,1, 3'd0,0,1,0,1);
    add(1,0,8'h00,0, 3'd0,0,1,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_ovf",      32'(ovf),      32'd0);
    chk("rst_unf",      32'(unf),      32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_data",     32'(data_rd),  32'd0);
    chk("rst_perr",     32'(perr),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].r, 1'b0);
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d full",  i), 32'(full),  32'(vecs[i].f));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e));
      chk($sformatf("v%0d ovf",   i), 32'(ovf),   32'(vecs[i].o));
      chk($sformatf("v%0d unf",   i), 32'(unf),   32'(vecs[i].u));
    end

    // asynchronous reset while a read result is being presented
    step(0, 1, 8'h71, 0, 1'b0);
    step(0, 1, 8'h72, 0, 1'b0);
    step(0, 0, 8'h00, 1, 1'b0);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_count", 32'(count),    32'd0);
    chk("midrst_empty", 32'(empty),    32'd1);
    chk("midrst_data",  32'(data_rd),  32'd0);
    mq.delete(); sb.delete(); last_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 8'h80, 0, 1'b0);
    chk("postrst_count", 32'(count), 32'd1);
    step(0, 0, 8'h00, 1, 1'b0);
    chk("postrst_empty", 32'(empty), 32'd1);

`ifdef RAM_WR_BUFFER_PARITY_EN
    step(1, 0, 8'h00, 0, 1'b0);
    par_inj = 1'b1;
    step(0, 1, 8'h3C, 0, 1'b0);
    par_inj = 1'b0;
    step(0, 1, 8'h3D, 0, 1'b0);
    step(0, 0, 8'h00, 1, 1'b1);
    step(0, 0, 8'h00, 1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
